// File: rtl/lc3_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lc3_ctrl_pkg
//  Purpose  : Sequencer states and datapath select encodings for the LC-3.
//  Revision : 1.0  initial release
// ============================================================================
package lc3_ctrl_pkg;
    import lc3_isa_pkg::*;

    typedef enum logic [4:0] {
        S_FETCH0, S_FETCH1, S_FETCH2, S_DECODE,
        S_EX_ALU, S_EX_BR, S_EX_JMP, S_EX_JSR, S_EX_LEA,
        S_ADDR, S_RD, S_IND, S_WB, S_SDATA, S_WR,
        S_TR0, S_TR1, S_TR2, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        GATE_NONE, GATE_PC, GATE_MARMUX, GATE_ALU, GATE_MDR
    } gate_sel_t;

    typedef enum logic [1:0] {ALU_ADD, ALU_AND, ALU_NOT, ALU_PASSA} alu_op_t;

    typedef enum logic [1:0] {PC_INC, PC_ADDER, PC_BUS} pc_sel_t;

    typedef enum logic [2:0] {
        ADDR_PC_OFF9, ADDR_PC_OFF11, ADDR_BASE_OFF6, ADDR_BASE_0, ADDR_TRAPVECT
    } addr_sel_t;

    typedef struct packed {
        logic      mem_en;
        logic      mem_we;
        logic      ld_mar;
        logic      ld_mdr;
        logic      ld_ir;
        logic      ld_pc;
        logic      ld_reg;
        logic      ld_cc;
        logic      mdr_sel;
        gate_sel_t gate_sel;
        alu_op_t   alu_op;
        pc_sel_t   pc_sel;
        addr_sel_t addr_sel;
        logic      dr_sel;
        logic      sr1_sel;
        logic      instr_done;
    } ctrl_t;

    // LDI and STI make a second memory pass through the pointer.
    function automatic logic is_ind_op(input logic [3:0] op);
        return (op == OP_LDI) || (op == OP_STI);
    endfunction
endpackage
`default_nettype wire

// File: rtl/lc3_isa_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lc3_isa_pkg
//  Purpose  : LC-3 opcode constants shared by the datapath and the sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package lc3_isa_pkg;
    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_RTI  = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_RES  = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;
endpackage
`default_nettype wire

// File: rtl/lc3_ctrl_outputs.sv
`default_nettype none
// ============================================================================
//  Module   : lc3_ctrl_outputs
//  Purpose  : Combinational decode of sequencer state into the control word.
//  Revision : 1.0  initial release
// ============================================================================
module lc3_ctrl_outputs
    import lc3_isa_pkg::*;
    import lc3_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [6:0] ir_hi,
    input  logic [2:0] nzp,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);
    logic [3:0] w_opcode;
    assign w_opcode = ir_hi[6:3];

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH0: begin
                ctrl.gate_sel = GATE_PC;
                ctrl.ld_mar   = 1'b1;
                ctrl.ld_pc    = 1'b1;
                ctrl.pc_sel   = PC_INC;
            end
            S_FETCH1, S_RD: begin
                ctrl.mem_en = 1'b1;
                ctrl.ld_mdr = mem_ready;
            end
            S_FETCH2: begin
                ctrl.gate_sel = GATE_MDR;
                ctrl.ld_ir    = 1'b1;
            end
            S_EX_ALU: begin
                ctrl.gate_sel   = GATE_ALU;
                ctrl.ld_reg     = 1'b1;
                ctrl.ld_cc      = 1'b1;
                ctrl.instr_done = 1'b1;
                if (w_opcode == OP_AND)      ctrl.alu_op = ALU_AND;
                else if (w_opcode == OP_NOT) ctrl.alu_op = ALU_NOT;
                else                         ctrl.alu_op = ALU_ADD;
            end
            S_EX_BR: begin
                ctrl.instr_done = 1'b1;
                if (|(ir_hi[2:0] & nzp)) begin
                    ctrl.ld_pc    = 1'b1;
                    ctrl.pc_sel   = PC_ADDER;
                    ctrl.addr_sel = ADDR_PC_OFF9;
                end
            end
            S_EX_JMP: begin
                ctrl.ld_pc      = 1'b1;
                ctrl.pc_sel     = PC_ADDER;
                ctrl.addr_sel   = ADDR_BASE_0;
                ctrl.instr_done = 1'b1;
            end
            S_EX_JSR: begin
                // Old PC goes to R7 over the bus while the adder feeds the PC.
                ctrl.gate_sel   = GATE_PC;
                ctrl.ld_reg     = 1'b1;
                ctrl.dr_sel     = 1'b1;
                ctrl.ld_pc      = 1'b1;
                ctrl.pc_sel     = PC_ADDER;
                ctrl.addr_sel   = ir_hi[2] ? ADDR_PC_OFF11 : ADDR_BASE_0;
                ctrl.instr_done = 1'b1;
            end
            S_EX_LEA: begin
                ctrl.gate_sel   = GATE_MARMUX;
                ctrl.addr_sel   = ADDR_PC_OFF9;
                ctrl.ld_reg     = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_ADDR: begin
                ctrl.gate_sel = GATE_MARMUX;
                ctrl.ld_mar   = 1'b1;
                ctrl.addr_sel = (w_opcode == OP_LDR || w_opcode == OP_STR) ?
                                ADDR_BASE_OFF6 : ADDR_PC_OFF9;
            end
            S_IND: begin
                ctrl.gate_sel = GATE_MDR;
                ctrl.ld_mar   = 1'b1;
            end
            S_WB: begin
                ctrl.gate_sel   = GATE_MDR;
                ctrl.ld_reg     = 1'b1;
                ctrl.ld_cc      = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_SDATA: begin
                ctrl.gate_sel = GATE_ALU;
                ctrl.alu_op   = ALU_PASSA;
                ctrl.sr1_sel  = 1'b1;
                ctrl.ld_mdr   = 1'b1;
                ctrl.mdr_sel  = 1'b1;
            end
            S_WR: begin
                ctrl.mem_en     = 1'b1;
                ctrl.mem_we     = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_TR0: begin
                ctrl.gate_sel = GATE_MARMUX;
                ctrl.addr_sel = ADDR_TRAPVECT;
                ctrl.ld_mar   = 1'b1;
            end
            S_TR1: begin
                ctrl.gate_sel = GATE_PC;
                ctrl.ld_reg   = 1'b1;
                ctrl.dr_sel   = 1'b1;
            end
            S_TR2: begin
                ctrl.gate_sel   = GATE_MDR;
                ctrl.ld_pc      = 1'b1;
                ctrl.pc_sel     = PC_BUS;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/lc3_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : lc3_control_fsm
//  Purpose  : LC-3 multicycle sequencer: state register, dispatch, handshake.
//  Revision : 1.0  initial release
// ============================================================================
module lc3_control_fsm
    import lc3_isa_pkg::*;
    import lc3_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic [2:0]  nzp,
    input  logic        mem_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic        ld_mar,
    output logic        ld_mdr,
    output logic        ld_ir,
    output logic        ld_pc,
    output logic        ld_reg,
    output logic        ld_cc,
    output logic        mdr_sel,
    output logic [2:0]  gate_sel,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_sel,
    output logic [2:0]  addr_sel,
    output logic        dr_sel,
    output logic        sr1_sel,
    output logic        instr_done,
    output logic        halted
);
    state_t     state_q, state_d;
    logic       ind_phase_q, ind_phase_d;
    logic       halted_q, halted_d;
    logic [3:0] w_opcode;
    logic       w_unused_ir;
    ctrl_t      w_ctrl, w_ctrl_gated;

    assign w_opcode    = ir[15:12];
    assign w_unused_ir = ^ir[8:0];

    lc3_ctrl_outputs u_outputs (
        .state     (state_q),
        .ir_hi     (ir[15:9]),
        .nzp       (nzp),
        .mem_ready (mem_ready),
        .ctrl      (w_ctrl)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FETCH0;
            ind_phase_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ind_phase_q <= ind_phase_d;
            halted_q    <= halted_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ind_phase_d = ind_phase_q;
        halted_d    = halted_q;
        case (state_q)
            S_FETCH0: begin
                ind_phase_d = 1'b0;
                state_d     = S_FETCH1;
            end
            S_FETCH1: if (mem_ready) state_d = S_FETCH2;
            S_FETCH2: state_d = S_DECODE;
            S_DECODE: begin
                case (w_opcode)
                    OP_ADD, OP_AND, OP_NOT:               state_d = S_EX_ALU;
                    OP_BR:                                state_d = S_EX_BR;
                    OP_JMP:                               state_d = S_EX_JMP;
                    OP_JSR:                               state_d = S_EX_JSR;
                    OP_LEA:                               state_d = S_EX_LEA;
                    OP_LD, OP_LDR, OP_LDI,
                    OP_ST, OP_STR, OP_STI:                state_d = S_ADDR;
                    OP_TRAP:                              state_d = S_TR0;
                    default: begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end
                endcase
            end
            S_ADDR: state_d = (w_opcode == OP_ST || w_opcode == OP_STR) ? S_SDATA : S_RD;
            S_RD: begin
                // One read state serves fetch of the pointer and of the data.
                if (mem_ready) begin
                    if (is_ind_op(w_opcode) && !ind_phase_q) state_d = S_IND;
                    else if (w_opcode == OP_TRAP)            state_d = S_TR2;
                    else                                     state_d = S_WB;
                end
            end
            S_IND: begin
                ind_phase_d = 1'b1;
                state_d     = (w_opcode == OP_STI) ? S_SDATA : S_RD;
            end
            S_SDATA: state_d = S_WR;
            S_WR:    if (mem_ready) state_d = S_FETCH0;
            S_TR0:   state_d = S_TR1;
            S_TR1:   state_d = S_RD;
            S_EX_ALU, S_EX_BR, S_EX_JMP, S_EX_JSR, S_EX_LEA, S_WB, S_TR2:
                     state_d = S_FETCH0;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH0;
        endcase
    end

    always_comb begin
        w_ctrl_gated = w_ctrl;
        if (rst) w_ctrl_gated = '0;
    end

    assign mem_en     = w_ctrl_gated.mem_en;
    assign mem_we     = w_ctrl_gated.mem_we;
    assign ld_mar     = w_ctrl_gated.ld_mar;
    assign ld_mdr     = w_ctrl_gated.ld_mdr;
    assign ld_ir      = w_ctrl_gated.ld_ir;
    assign ld_pc      = w_ctrl_gated.ld_pc;
    assign ld_reg     = w_ctrl_gated.ld_reg;
    assign ld_cc      = w_ctrl_gated.ld_cc;
    assign mdr_sel    = w_ctrl_gated.mdr_sel;
    assign gate_sel   = w_ctrl_gated.gate_sel;
    assign alu_op     = w_ctrl_gated.alu_op;
    assign pc_sel     = w_ctrl_gated.pc_sel;
    assign addr_sel   = w_ctrl_gated.addr_sel;
    assign dr_sel     = w_ctrl_gated.dr_sel;
    assign sr1_sel    = w_ctrl_gated.sr1_sel;
    assign instr_done = w_ctrl_gated.instr_done;
    assign halted     = halted_q & ~rst;
endmodule
`default_nettype wire

// File: tb/tb_lc3_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lc3_control_fsm
//  Purpose  : Directed cycle-by-cycle check of the LC-3 control sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lc3_control_fsm;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ir;
    logic [2:0]  nzp;
    logic        mem_ready;
    logic        mem_en, mem_we, ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc, mdr_sel;
    logic [2:0]  gate_sel, addr_sel;
    logic [1:0]  alu_op, pc_sel;
    logic        dr_sel, sr1_sel, instr_done, halted;
    logic [22:0] obs;
    int          n_asrt = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    lc3_control_fsm dut (
        .clk(clk), .rst(rst), .ir(ir), .nzp(nzp), .mem_ready(mem_ready),
        .mem_en(mem_en), .mem_we(mem_we), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
        .ld_ir(ld_ir), .ld_pc(ld_pc), .ld_reg(ld_reg), .ld_cc(ld_cc),
        .mdr_sel(mdr_sel), .gate_sel(gate_sel), .alu_op(alu_op), .pc_sel(pc_sel),
        .addr_sel(addr_sel), .dr_sel(dr_sel), .sr1_sel(sr1_sel),
        .instr_done(instr_done), .halted(halted)
    );

    // {mem_en,mem_we,ld_mar,ld_mdr,ld_ir,ld_pc,ld_reg,ld_cc,mdr_sel, gate,alu,pc,addr, dr,sr1,done,halted}
    assign obs = {mem_en, mem_we, ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc, mdr_sel,
                  gate_sel, alu_op, pc_sel, addr_sel, dr_sel, sr1_sel, instr_done, halted};

    localparam logic [22:0] W_ZERO = '0;
    localparam logic [22:0] W_F0   = {9'b001001000, 3'd1, 2'd0, 2'd0, 3'd0, 4'b0000};
    localparam logic [22:0] W_MRD  = {9'b100100000, 3'd0, 2'd0, 2'd0, 3'd0, 4'b0000};
    localparam logic [22:0] W_MWT  = {9'b100000000, 3'd0, 2'd0, 2'd0, 3'd0, 4'b0000};
    localparam logic [22:0] W_F2   = {9'b000010000, 3'd4, 2'd0, 2'd0, 3'd0, 4'b0000};
    localparam logic [22:0] W_ADD  = {9'b000000110, 3'd3, 2'd0, 2'd0, 3'd0, 4'b0010};
    localparam logic [22:0] W_AND  = {9'b000000110, 3'd3, 2'd1, 2'd0, 3'd0, 4'b0010};
    localparam logic [22:0] W_NOT  = {9'b000000110, 3'd3, 2'd2, 2'd0, 3'd0, 4'b0010};
    localparam logic [22:0] W_BRT  = {9'b000001000, 3'd0, 2'd0, 2'd1, 3'd0, 4'b0010};
    localparam logic [22:0] W_BRN  = {9'b000000000, 3'd0, 2'd0, 2'd0, 3'd0, 4'b0010};
    localparam logic [22:0] W_JMP  = {9'b000001000, 3'd0, 2'd0, 2'd1, 3'd3, 4'b0010};
    localparam logic [22:0] W_JSR  = {9'b000001100, 3'd1, 2'd0, 2'd1, 3'd1, 4'b1010};
    localparam logic [22:0] W_JSRR = {9'b000001100, 3'd1, 2'd0, 2'd1, 3'd3, 4'b1010};
    localparam logic [22:0] W_LEA  = {9'b000000100, 3'd2, 2'd0, 2'd0, 3'd0, 4'b0010};
    localparam logic [22:0] W_ADR9 = {9'b001000000, 3'd2, 2'd0, 2'd0, 3'd0, 4'b0000};
    localparam logic [22:0] W_ADR6 = {9'b001000000, 3'd2, 2'd0, 2'd0, 3'd2, 4'b0000};
    localparam logic [22:0] W_IND  = {9'b001000000, 3'd4, 2'd0, 2'd0, 3'd0, 4'b0000};
    localparam logic [22:0] W_WB   = {9'b000000110, 3'd4, 2'd0, 2'd0, 3'd0, 4'b0010};
    localparam logic [22:0] W_SDAT = {9'b000100001, 3'd3, 2'd3, 2'd0, 3'd0, 4'b0100};
    localparam logic [22:0] W_WRW  = {9'b110000000, 3'd0, 2'd0, 2'd0, 3'd0, 4'b0000};
    localparam logic [22:0] W_WRD  = {9'b110000000, 3'd0, 2'd0, 2'd0, 3'd0, 4'b0010};
    localparam logic [22:0] W_TR0  = {9'b001000000, 3'd2, 2'd0, 2'd0, 3'd4, 4'b0000};
    localparam logic [22:0] W_TR1  = {9'b000000100, 3'd1, 2'd0, 2'd0, 3'd0, 4'b1000};
    localparam logic [22:0] W_TR2  = {9'b000001000, 3'd4, 2'd0, 2'd2, 3'd0, 4'b0010};
    localparam logic [22:0] W_HALT = 23'd1;

    task automatic check(input string tag, input logic [22:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %06h expected %06h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive mem_ready, check the control word, advance.
    task automatic cyc(input logic rdy, input logic [22:0] exp, input string tag);
        mem_ready = rdy;
        #1;
        check(tag, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [15:0] instr, input string name);
        ir = instr;
        cyc(1'b1, W_F0,   {name, ".fetch0"});
        cyc(1'b1, W_MRD,  {name, ".fetch1"});
        cyc(1'b1, W_F2,   {name, ".fetch2"});
        cyc(1'b1, W_ZERO, {name, ".decode"});
    endtask

    initial begin
        rst = 1'b1; ir = 16'hF025; nzp = 3'b000; mem_ready = 1'b1;
        @(posedge clk); #1;
        check("reset.a", W_ZERO);
        @(posedge clk); #1;
        check("reset.b", W_ZERO);
        rst = 1'b0;

        fetch(16'h1283, "add");  cyc(1'b1, W_ADD,  "add.ex");
        fetch(16'h5283, "and");  cyc(1'b1, W_AND,  "and.ex");
        fetch(16'h927F, "not");  cyc(1'b1, W_NOT,  "not.ex");

        nzp = 3'b010;
        fetch(16'h0402, "brt");  cyc(1'b1, W_BRT,  "br.taken");
        nzp = 3'b001;
        fetch(16'h0402, "brn");  cyc(1'b1, W_BRN,  "br.not_taken");

        fetch(16'hC1C0, "jmp");  cyc(1'b1, W_JMP,  "jmp.ex");
        fetch(16'h4803, "jsr");  cyc(1'b1, W_JSR,  "jsr.ex");
        fetch(16'h41C0, "jsrr"); cyc(1'b1, W_JSRR, "jsrr.ex");
        fetch(16'hE3FF, "lea");  cyc(1'b1, W_LEA,  "lea.ex");

        fetch(16'h2205, "ld");
        cyc(1'b1, W_ADR9, "ld.addr"); cyc(1'b1, W_MRD, "ld.rd"); cyc(1'b1, W_WB, "ld.wb");
        fetch(16'h6245, "ldr");
        cyc(1'b1, W_ADR6, "ldr.addr"); cyc(1'b1, W_MRD, "ldr.rd"); cyc(1'b1, W_WB, "ldr.wb");

        // LDI, every access waits three cycles: instr_done on the 18th cycle.
        ir = 16'hA201;
        cyc(1'b0, W_F0, "ldi.fetch0");
        repeat (3) cyc(1'b0, W_MWT, "ldi.fetch1.wait");
        cyc(1'b1, W_MRD,  "ldi.fetch1.xfer");
        cyc(1'b0, W_F2,   "ldi.fetch2");
        cyc(1'b0, W_ZERO, "ldi.decode");
        cyc(1'b0, W_ADR9, "ldi.addr");
        repeat (3) cyc(1'b0, W_MWT, "ldi.rd1.wait");
        cyc(1'b1, W_MRD,  "ldi.rd1.xfer");
        cyc(1'b0, W_IND,  "ldi.ind");
        repeat (3) cyc(1'b0, W_MWT, "ldi.rd2.wait");
        cyc(1'b1, W_MRD,  "ldi.rd2.xfer");
        cyc(1'b0, W_WB,   "ldi.wb");

        fetch(16'h3205, "st");
        cyc(1'b1, W_ADR9, "st.addr"); cyc(1'b1, W_SDAT, "st.sdata");
        cyc(1'b0, W_WRW,  "st.wr.wait"); cyc(1'b1, W_WRD, "st.wr.xfer");

        fetch(16'hB3FF, "sti");
        cyc(1'b1, W_ADR9, "sti.addr"); cyc(1'b1, W_MRD, "sti.rd");
        cyc(1'b1, W_IND,  "sti.ind");  cyc(1'b1, W_SDAT, "sti.sdata");
        cyc(1'b1, W_WRD,  "sti.wr.xfer");

        fetch(16'h7245, "str");
        cyc(1'b1, W_ADR6, "str.addr"); cyc(1'b1, W_SDAT, "str.sdata");
        cyc(1'b1, W_WRD,  "str.wr.xfer");

        fetch(16'hF025, "trap");
        cyc(1'b1, W_TR0, "trap.tr0"); cyc(1'b1, W_TR1, "trap.tr1");
        cyc(1'b1, W_MRD, "trap.rd");  cyc(1'b1, W_TR2, "trap.tr2");
        cyc(1'b1, W_F0,  "trap.next_fetch0");

        // Reset during a pending write abandons it in the same cycle.
        cyc(1'b1, W_MRD,  "st2.fetch1"); cyc(1'b1, W_F2, "st2.fetch2");
        ir = 16'h3205;
        cyc(1'b1, W_ZERO, "st2.decode");
        cyc(1'b1, W_ADR9, "st2.addr"); cyc(1'b1, W_SDAT, "st2.sdata");
        mem_ready = 1'b0; #1;
        check("st2.wr.wait", W_WRW);
        rst = 1'b1; #1;
        check("rst_in_wr", W_ZERO);
        @(posedge clk); #1;
        rst = 1'b0; ir = 16'h1283;
        cyc(1'b0, W_F0,   "after_rst.fetch0");
        cyc(1'b1, W_MRD,  "after_rst.fetch1");
        cyc(1'b1, W_F2,   "after_rst.fetch2");
        cyc(1'b1, W_ZERO, "after_rst.decode");
        cyc(1'b1, W_ADD,  "after_rst.add");

        // Reserved opcode halts until reset.
        fetch(16'hD000, "res");
        cyc(1'b0, W_HALT, "halt.a");
        ir = 16'h1283;
        cyc(1'b1, W_HALT, "halt.b");
        cyc(1'b1, W_HALT, "halt.c");
        rst = 1'b1; #1;
        check("halt.rst", W_ZERO);
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(1'b1, W_F0, "halt.recover_fetch0");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
